// File: rtl/dmem_if.sv
// Load/store request/response bundle between the core datapath (master) and the data memory (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// RV64 data-memory responder: one request at a time, sub-word load/store on a 64-bit synchronous RAM.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned accesses instead of aligning the offset down.
module dmem_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  dmem
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t        state_q;
    logic          we_q;
    logic [2:0]    func3_q;
    logic [AW-1:0] idx_q;
    logic [2:0]    off_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rd_word_q;
    logic          resp_valid_q;
    logic [63:0]   resp_rdata_q;
    logic          resp_err_q;
    logic [63:0]   mem [DEPTH];

    logic          ready;
    logic          mis;
    logic [2:0]    off_eff;
    logic [63:0]   wr_word_d;
    logic          unused_addr;

    // Access size is func3[1:0] for both loads and stores (111 decodes as a doubleword).
    function automatic logic [2:0] align_off(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'b00:   align_off = off;
            2'b01:   align_off = {off[2:1], 1'b0};
            2'b10:   align_off = {off[2], 2'b00};
            default: align_off = 3'b000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off[1:0];
            2'b11:   misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] load_ext(input logic [63:0] word, input logic [2:0] f3,
                                             input logic [2:0] off);
        logic [63:0]        sh;
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        logic signed [31:0] w32;
        sh  = word >> {off, 3'b000};
        b8  = sh[7:0];
        h16 = sh[15:0];
        w32 = sh[31:0];
        case (f3)
            3'b000:  load_ext = 64'(b8);
            3'b001:  load_ext = 64'(h16);
            3'b010:  load_ext = 64'(w32);
            3'b100:  load_ext = {56'd0, sh[7:0]};
            3'b101:  load_ext = {48'd0, sh[15:0]};
            3'b110:  load_ext = {32'd0, sh[31:0]};
            default: load_ext = sh;
        endcase
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] wd,
                                                input logic [2:0] f3, input logic [2:0] off);
        logic [63:0] m;
        case (f3[1:0])
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            2'b10:   m = 64'h0000_0000_FFFF_FFFF;
            default: m = '1;
        endcase
        m = m << {off, 3'b000};
        store_merge = (old & ~m) | ((wd << {off, 3'b000}) & m);
    endfunction

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis     = misaligned(func3_q, off_q);
    assign off_eff = off_q;
`else
    assign mis     = 1'b0;
    assign off_eff = align_off(func3_q, off_q);
`endif

    assign ready       = (state_q == IDLE) && reset;
    assign wr_word_d   = store_merge(rd_word_q, wdata_q, func3_q, off_eff);
    assign unused_addr = ^dmem.req_addr[63:AW+3];

    assign dmem.req_ready  = ready;
    assign dmem.resp_valid = resp_valid_q;
    assign dmem.resp_rdata = resp_rdata_q;
    assign dmem.resp_err   = resp_err_q;

    // Control FSM; response outputs are registered on entry to RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (dmem.req_valid) state_q <= RD;
                RD: begin
                    if (we_q) begin
                        state_q <= WR;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= mis ? '0 : load_ext(mem[idx_q], func3_q, off_eff);
                        resp_err_q   <= mis;
                    end
                end
                WR: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                    resp_err_q   <= mis;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request capture and read-word staging (datapath, no reset).
    always_ff @(posedge clk) begin
        if (dmem.req_valid && ready) begin
            we_q    <= dmem.req_we;
            func3_q <= dmem.req_func3;
            idx_q   <= dmem.req_addr[AW+2:3];
            off_q   <= dmem.req_addr[2:0];
            wdata_q <= dmem.req_wdata;
        end
        if (state_q == RD) rd_word_q <= mem[idx_q];
    end

    // A reset on the WR-exit edge drops the write.
    always_ff @(posedge clk) begin
        if (reset && (state_q == WR) && !mis) mem[idx_q] <= wr_word_d;
    end
endmodule
